// File: rtl/lane_scheduler.sv
// lane_scheduler
//   Order-preserving dispatcher/collector that spreads one request stream over
//   LANES external multiplier lanes and returns responses strictly in request
//   order. Each accepted request goes to the first ready lane in rotating
//   priority; the chosen lane index is queued in an order FIFO whose head
//   selects which lane may deliver next.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   in_valid/in_ready/in_data            upstream request ({b, a})
//   lane_in_valid/lane_in_ready          one-hot per-lane request handshake
//   lane_in_data                         request broadcast to every lane
//   lane_out_valid/lane_out_ready        one-hot per-lane response handshake
//   lane_out_data                        lane i at [i*2*WIDTH +: 2*WIDTH]
//   out_valid/out_ready/out_data         in-order response stream
//   inflight                             accepted but not yet delivered count
module lane_scheduler #(
  parameter int LANES            = 2,
  parameter int WIDTH            = 4,
  parameter int ORDER_DEPTH_BITS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [2*WIDTH-1:0]           in_data,
  output logic                         in_ready,
  output logic [LANES-1:0]             lane_in_valid,
  output logic [2*WIDTH-1:0]           lane_in_data,
  input  logic [LANES-1:0]             lane_in_ready,
  input  logic [LANES-1:0]             lane_out_valid,
  input  logic [LANES*2*WIDTH-1:0]     lane_out_data,
  output logic [LANES-1:0]             lane_out_ready,
  output logic                         out_valid,
  output logic [2*WIDTH-1:0]           out_data,
  input  logic                         out_ready,
  output logic [ORDER_DEPTH_BITS:0]    inflight
);

  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DW    = 2 * WIDTH;
  localparam int DEPTH = 1 << ORDER_DEPTH_BITS;
  localparam int PW    = ORDER_DEPTH_BITS + 1;

  logic [LW-1:0]      rr_ptr;
  logic [LW-1:0]      grant;
  logic               any_ready;
  logic [2*LANES-1:0] ready_rot;

  logic [LW-1:0]      order_mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               order_full;
  logic               order_empty;
  logic [LW-1:0]      head;
  logic               head_valid;

  logic               push;
  logic               pop;

  // Lane index base+off, wrapping at LANES (LANES need not be a power of two).
  function automatic logic [LW-1:0] lane_add(input logic [LW-1:0] base,
                                             input int unsigned  off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= LANES) s = s - LANES;
    return LW'(s);
  endfunction

  // Rotating-priority grant: bit i of ready_rot is the readiness of lane
  // rr_ptr+i, so the lowest set bit in the low LANES bits is the winner.
  assign ready_rot = {lane_in_ready, lane_in_ready} >> rr_ptr;

  always_comb begin
    grant     = '0;
    any_ready = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!any_ready && ready_rot[i]) begin
        any_ready = 1'b1;
        grant     = lane_add(rr_ptr, i);
      end
    end
  end

  // Order FIFO status; the extra pointer MSB separates full from empty.
  assign order_empty = (wr_ptr == rd_ptr);
  assign order_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                       (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign head        = order_mem[rd_ptr[PW-2:0]];

  // Dispatch side. in_ready deliberately ignores in_valid and any pop in the
  // same cycle, so a full FIFO never passes a request through.
  assign in_ready     = !rst && any_ready && !order_full;
  assign push         = in_valid && in_ready;
  assign lane_in_data = in_data;

  always_comb begin
    lane_in_valid = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_in_valid[i] = push && (grant == LW'(i));
    end
  end

  // Collect side: only the head lane is ever offered ready, so a response
  // that completes early on another lane stays parked inside that lane.
  always_comb begin
    head_valid     = 1'b0;
    out_data       = '0;
    lane_out_ready = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (head == LW'(i)) begin
        head_valid        = lane_out_valid[i];
        out_data          = lane_out_data[i*DW +: DW];
        lane_out_ready[i] = out_ready && !order_empty && !rst;
      end
    end
  end

  assign out_valid = !rst && !order_empty && head_valid;
  assign pop       = out_valid && out_ready;

  // Index storage needs no reset: the pointers are cleared, so stale entries
  // are never read as a head after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      order_mem[wr_ptr[PW-2:0]] <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= lane_add(grant, 1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_scheduler.sv
// tb_lane_scheduler
//   Directed bench for lane_scheduler with LANES=2, WIDTH=4, depth 4. The
//   lanes themselves are not modelled; the bench plays their handshake and
//   supplies hand-computed products on lane_out_data.
module tb_lane_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [1:0]  lane_in_valid;
  logic [7:0]  lane_in_data;
  logic [1:0]  lane_in_ready;
  logic [1:0]  lane_out_valid;
  logic [15:0] lane_out_data;
  logic [1:0]  lane_out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [2:0]  inflight;

  int checks   = 0;
  int failures = 0;

  lane_scheduler #(
    .LANES            (2),
    .WIDTH            (4),
    .ORDER_DEPTH_BITS (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .lane_in_valid  (lane_in_valid),
    .lane_in_data   (lane_in_data),
    .lane_in_ready  (lane_in_ready),
    .lane_out_valid (lane_out_valid),
    .lane_out_data  (lane_out_data),
    .lane_out_ready (lane_out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .inflight       (inflight)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h53;
    lane_in_ready = 2'b11; lane_out_valid = 2'b11; lane_out_data = 16'h0000;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_lane_in_valid", lane_in_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lane_out_ready", lane_out_ready, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0; lane_out_valid = 2'b00; out_ready = 1'b0;
    #1;
    chk("rst_inflight", inflight, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // ---------------- ordered dispatch ----------------
    in_valid = 1'b1; in_data = 8'h53; #1;          // a=3 b=5
    chk("ord_in_ready", in_ready, 1);
    chk("ord_grant0", lane_in_valid, 2'b01);
    chk("ord_bcast", lane_in_data, 8'h53);
    tick();
    in_data = 8'h72; #1;                           // a=2 b=7
    chk("ord_grant1", lane_in_valid, 2'b10);
    tick();
    in_data = 8'hFF; #1;                           // a=15 b=15
    chk("ord_grant2", lane_in_valid, 2'b01);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    lane_out_valid = 2'b11; lane_out_data = {8'd14, 8'd15}; #1;
    chk("ord_inflight3", inflight, 3);
    chk("ord_ov0", out_valid, 1);
    chk("ord_od0", out_data, 8'd15);
    chk("ord_lor0", lane_out_ready, 2'b01);
    tick();
    lane_out_data = {8'd14, 8'd225}; #1;
    chk("ord_od1", out_data, 8'd14);
    chk("ord_lor1", lane_out_ready, 2'b10);
    tick();
    lane_out_valid = 2'b01; #1;
    chk("ord_od2", out_data, 8'd225);
    chk("ord_lor2", lane_out_ready, 2'b01);
    tick();
    out_ready = 1'b0; lane_out_valid = 2'b00; #1;
    chk("ord_inflight0", inflight, 0);
    chk("ord_empty_ov", out_valid, 0);

    // ---------------- skip busy lane ----------------
    // Accept on lane 1 only, then peek with both ready: lane 0 wins if rr_ptr=0.
    in_valid = 1'b1; lane_in_ready = 2'b10; in_data = 8'h21; #1;   // 1*2
    chk("skip_g0", lane_in_valid, 2'b10);
    tick();
    lane_in_ready = 2'b11; #1;
    chk("skip_rr0", lane_in_valid, 2'b01);
    lane_in_ready = 2'b10; in_data = 8'h44; #1;                    // 4*4
    chk("skip_g1", lane_in_valid, 2'b10);
    tick();
    lane_in_ready = 2'b11; #1;
    chk("skip_rr1", lane_in_valid, 2'b01);
    lane_in_ready = 2'b10; in_data = 8'h1F; #1;                    // 15*1
    chk("skip_g2", lane_in_valid, 2'b10);
    tick();
    lane_in_ready = 2'b11; #1;
    chk("skip_rr2", lane_in_valid, 2'b01);
    in_valid = 1'b0;
    out_ready = 1'b1; lane_out_valid = 2'b10; lane_out_data = {8'd2, 8'h00}; #1;
    chk("skip_od0", out_data, 8'd2);
    chk("skip_lor0", lane_out_ready, 2'b10);
    tick();
    lane_out_data = {8'd16, 8'h00}; #1;
    chk("skip_od1", out_data, 8'd16);
    tick();
    lane_out_data = {8'd15, 8'h00}; #1;
    chk("skip_od2", out_data, 8'd15);
    chk("skip_ov2", out_valid, 1);
    tick();
    out_ready = 1'b0; lane_out_valid = 2'b00; #1;
    chk("skip_inflight0", inflight, 0);

    // ---------------- out-of-order completion ----------------
    in_valid = 1'b1; in_data = 8'h36; #1;          // a=6 b=3 -> 18
    chk("ooo_g0", lane_in_valid, 2'b01);
    tick();
    in_data = 8'h55; #1;                           // a=5 b=5 -> 25
    chk("ooo_g1", lane_in_valid, 2'b10);
    tick();
    in_valid = 1'b0; lane_out_valid = 2'b10; lane_out_data = {8'd25, 8'hAA}; #1;
    chk("ooo_wait_ov0", out_valid, 0);
    chk("ooo_wait_lor0", lane_out_ready, 2'b00);
    tick();
    #1;
    chk("ooo_wait_ov1", out_valid, 0);
    chk("ooo_wait_lor1", lane_out_ready, 2'b00);
    chk("ooo_wait_inflight", inflight, 2);
    tick();
    out_ready = 1'b1; lane_out_valid = 2'b11; lane_out_data = {8'd25, 8'd18}; #1;
    chk("ooo_ov0", out_valid, 1);
    chk("ooo_od0", out_data, 8'd18);
    chk("ooo_lor0", lane_out_ready, 2'b01);
    tick();
    lane_out_valid = 2'b10; #1;
    chk("ooo_od1", out_data, 8'd25);
    chk("ooo_lor1", lane_out_ready, 2'b10);
    tick();
    out_ready = 1'b0; lane_out_valid = 2'b00; #1;
    chk("ooo_inflight0", inflight, 0);

    // ---------------- full order FIFO ----------------
    in_valid = 1'b1; in_data = 8'h11; #1;          // 1  -> lane 0
    chk("full_acc0", lane_in_valid, 2'b01);
    tick();
    in_data = 8'h32; #1;                           // 6  -> lane 1
    chk("full_acc1", lane_in_valid, 2'b10);
    tick();
    in_data = 8'h33; #1;                           // 9  -> lane 0
    chk("full_acc2", lane_in_valid, 2'b01);
    tick();
    in_data = 8'h54; #1;                           // 20 -> lane 1
    chk("full_acc3", in_ready, 1);
    tick();
    in_data = 8'h77; #1;
    chk("full_inflight4", inflight, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_no_lane_valid", lane_in_valid, 2'b00);
    tick();
    out_ready = 1'b1; lane_out_valid = 2'b01; lane_out_data = {8'h00, 8'd1}; #1;
    chk("full_pop_ov", out_valid, 1);
    chk("full_pop_od", out_data, 8'd1);
    chk("full_no_pass", in_ready, 0);
    chk("full_no_pass_lane", lane_in_valid, 2'b00);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; lane_out_valid = 2'b00; #1;
    chk("full_reassert", in_ready, 1);
    chk("full_inflight3", inflight, 3);

    // ---------------- backpressure hold ----------------
    lane_out_valid = 2'b10; lane_out_data = {8'd6, 8'hCC};
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ov", out_valid, 1);
      chk("bp_od", out_data, 8'd6);
      chk("bp_lor", lane_out_ready, 2'b00);
      chk("bp_inflight", inflight, 3);
      tick();
    end
    // Deliver the held response while accepting a new one on lane 0.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11; #1;
    chk("bp_release_od", out_data, 8'd6);
    chk("bp_release_lor", lane_out_ready, 2'b10);
    chk("bp_concurrent_acc", lane_in_valid, 2'b01);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; lane_out_valid = 2'b00; #1;
    chk("bp_inflight_same", inflight, 3);

    // ---------------- reset mid-operation ----------------
    rst = 1'b1; in_valid = 1'b1; lane_in_ready = 2'b11;
    lane_out_valid = 2'b11; out_ready = 1'b1; #1;
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_lane_in_valid", lane_in_valid, 2'b00);
    chk("mrst_lane_out_ready", lane_out_ready, 2'b00);
    tick();
    rst = 1'b0; in_valid = 1'b0; #1;
    chk("mrst_inflight0", inflight, 0);
    chk("mrst_out_valid_after", out_valid, 0);
    chk("mrst_lor_after", lane_out_ready, 2'b00);
    in_valid = 1'b1; in_data = 8'h23; #1;
    chk("mrst_first_grant", lane_in_valid, 2'b01);
    tick();
    in_valid = 1'b0; lane_out_valid = 2'b00; out_ready = 1'b0; #1;
    chk("mrst_inflight1", inflight, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
